// File: rtl/tesla_timing_pkg.sv
// Shared types and defaults for the drive-timing period path.
package tesla_timing_pkg;

  localparam int unsigned PERIOD_WIDTH       = 32;
  localparam int unsigned DEFAULT_MIN_PERIOD = 100;
  localparam int unsigned DEFAULT_MAX_PERIOD = 10000;

  typedef logic [PERIOD_WIDTH-1:0] period_t;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } tracker_state_e;

endpackage

// File: rtl/period_tracker_if.sv
// Bundle of the raw-sample input and filtered-period output of the tracker.
interface period_tracker_if
  import tesla_timing_pkg::*;
#(
  parameter int unsigned WIDTH = PERIOD_WIDTH
) ();

  logic [WIDTH-1:0] period_in;
  logic             period_in_valid;
  logic [WIDTH-1:0] period_out;
  logic [WIDTH-1:0] half_period_out;
  logic             period_out_valid;
  logic             locked;
  logic             reject_pulse;

  modport master (
    output period_in, period_in_valid,
    input  period_out, half_period_out, period_out_valid, locked, reject_pulse
  );

  modport slave (
    input  period_in, period_in_valid,
    output period_out, half_period_out, period_out_valid, locked, reject_pulse
  );

endinterface

// File: rtl/period_sample_check.sv
// Combinational range and outlier check of one raw period sample against the running average.
module period_sample_check
  import tesla_timing_pkg::*;
#(
  parameter int unsigned WIDTH      = PERIOD_WIDTH,
  parameter int unsigned MIN_PERIOD = DEFAULT_MIN_PERIOD,
  parameter int unsigned MAX_PERIOD = DEFAULT_MAX_PERIOD,
  parameter int unsigned TOL_SHIFT  = 3
) (
  input  logic [WIDTH-1:0] sample,
  input  logic [WIDTH-1:0] avg,
  input  logic             check_tol,
  output logic             in_range,
  output logic             accept
);

  logic [WIDTH-1:0] dev;
  logic [WIDTH-1:0] tol;

  always_comb begin
    in_range = (sample >= WIDTH'(MIN_PERIOD)) && (sample <= WIDTH'(MAX_PERIOD));
    // Subtract the smaller from the larger so the deviation never wraps.
    dev      = (sample >= avg) ? (sample - avg) : (avg - sample);
    tol      = avg >> TOL_SHIFT;
    accept   = in_range && (!check_tol || (dev <= tol));
  end

endmodule

// File: rtl/period_tracker.sv
// Filters raw period measurements into a validated moving average and reports lock status.
module period_tracker
  import tesla_timing_pkg::*;
#(
  parameter int unsigned WIDTH      = PERIOD_WIDTH,
  parameter int unsigned LOG2_AVG   = 3,
  parameter int unsigned MIN_PERIOD = DEFAULT_MIN_PERIOD,
  parameter int unsigned MAX_PERIOD = DEFAULT_MAX_PERIOD,
  parameter int unsigned TOL_SHIFT  = 3,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned MISS_LIMIT = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] period_in,
  input  logic             period_in_valid,
  output logic [WIDTH-1:0] period_out,
  output logic [WIDTH-1:0] half_period_out,
  output logic             period_out_valid,
  output logic             locked,
  output logic             reject_pulse
);

  localparam int unsigned SUM_W  = WIDTH + LOG2_AVG;
  localparam int unsigned FILL_W = LOG2_AVG + 1;
  localparam int unsigned GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam int unsigned MISS_W = $clog2(MISS_LIMIT + 1);

  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'((1 << LOG2_AVG) - 1);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_COUNT - 1);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_LIMIT - 1);

  tracker_state_e    state_q, state_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic [WIDTH-1:0]  out_d, half_d;
  logic              valid_d, reject_d;

  logic [WIDTH-1:0]  avg;
  logic [SUM_W-1:0]  sum_fill, sum_track;
  logic [WIDTH-1:0]  avg_fill, avg_track;
  logic              in_range, accept;

  assign avg       = sum_q[SUM_W-1:LOG2_AVG];
  assign sum_fill  = sum_q + SUM_W'(period_in);
  assign sum_track = sum_q - SUM_W'(avg) + SUM_W'(period_in);
  assign avg_fill  = sum_fill[SUM_W-1:LOG2_AVG];
  assign avg_track = sum_track[SUM_W-1:LOG2_AVG];
  assign locked    = (state_q == LOCKED);

  period_sample_check #(
    .WIDTH      (WIDTH),
    .MIN_PERIOD (MIN_PERIOD),
    .MAX_PERIOD (MAX_PERIOD),
    .TOL_SHIFT  (TOL_SHIFT)
  ) u_check (
    .sample    (period_in),
    .avg       (avg),
    .check_tol (state_q != FILL),
    .in_range  (in_range),
    .accept    (accept)
  );

  always_comb begin
    state_d  = state_q;
    sum_d    = sum_q;
    fill_d   = fill_q;
    good_d   = good_q;
    miss_d   = miss_q;
    out_d    = period_out;
    half_d   = half_period_out;
    valid_d  = 1'b0;
    reject_d = 1'b0;
    if (period_in_valid) begin
      unique case (state_q)
        FILL: begin
          if (in_range) begin
            sum_d  = sum_fill;
            fill_d = fill_q + 1'b1;
            if (fill_q == FILL_LAST) begin
              out_d   = avg_fill;
              half_d  = avg_fill >> 1;
              valid_d = 1'b1;
              fill_d  = '0;
              good_d  = '0;
              miss_d  = '0;
              state_d = TRACK;
            end
          end else begin
            reject_d = 1'b1;
          end
        end
        TRACK, LOCKED: begin
          if (accept) begin
            sum_d   = sum_track;
            out_d   = avg_track;
            half_d  = avg_track >> 1;
            valid_d = 1'b1;
            miss_d  = '0;
            if (state_q == TRACK) begin
              good_d = good_q + 1'b1;
              if (good_q == GOOD_LAST) state_d = LOCKED;
            end
          end else begin
            reject_d = 1'b1;
            good_d   = '0;
            miss_d   = miss_q + 1'b1;
            // Outputs deliberately hold their last estimate while re-acquiring.
            if (miss_q == MISS_LAST) begin
              state_d = FILL;
              sum_d   = '0;
              fill_d  = '0;
              miss_d  = '0;
            end
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= FILL;
      sum_q            <= '0;
      fill_q           <= '0;
      good_q           <= '0;
      miss_q           <= '0;
      period_out       <= '0;
      half_period_out  <= '0;
      period_out_valid <= 1'b0;
      reject_pulse     <= 1'b0;
    end else begin
      state_q          <= state_d;
      sum_q            <= sum_d;
      fill_q           <= fill_d;
      good_q           <= good_d;
      miss_q           <= miss_d;
      period_out       <= out_d;
      half_period_out  <= half_d;
      period_out_valid <= valid_d;
      reject_pulse     <= reject_d;
    end
  end

endmodule

// File: tb/tb_period_tracker.sv
// Directed self-checking bench for period_tracker with default parameters.
module tb_period_tracker;
  import tesla_timing_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  period_tracker_if #(.WIDTH(32)) bus ();

  period_tracker #(
    .WIDTH      (32),
    .LOG2_AVG   (3),
    .MIN_PERIOD (100),
    .MAX_PERIOD (10000),
    .TOL_SHIFT  (3),
    .LOCK_COUNT (4),
    .MISS_LIMIT (2)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .period_in        (bus.period_in),
    .period_in_valid  (bus.period_in_valid),
    .period_out       (bus.period_out),
    .half_period_out  (bus.half_period_out),
    .period_out_valid (bus.period_out_valid),
    .locked           (bus.locked),
    .reject_pulse     (bus.reject_pulse)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] p);
    bus.period_in       = p;
    bus.period_in_valid = 1'b1;
    @(posedge clock);
    #1;
    bus.period_in_valid = 1'b0;
  endtask

  task automatic send_n(input logic [31:0] p, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) send(p);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic idle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    bus.period_in       = '0;
    bus.period_in_valid = 1'b0;
    pulse_reset();
    chk("rst_out",    bus.period_out, 0);
    chk("rst_half",   bus.half_period_out, 0);
    chk("rst_valid",  {31'd0, bus.period_out_valid}, 0);
    chk("rst_locked", {31'd0, bus.locked}, 0);
    chk("rst_reject", {31'd0, bus.reject_pulse}, 0);

    // Out-of-range samples in FILL
    send(50);
    chk("oor_low_rej",   {31'd0, bus.reject_pulse}, 1);
    chk("oor_low_val",   {31'd0, bus.period_out_valid}, 0);
    send(20000);
    chk("oor_high_rej",  {31'd0, bus.reject_pulse}, 1);
    idle();
    chk("rej_one_cycle", {31'd0, bus.reject_pulse}, 0);

    // Fill still needs eight in-range samples
    send_n(1000, 7);
    chk("fill7_val",  {31'd0, bus.period_out_valid}, 0);
    chk("fill7_out",  bus.period_out, 0);
    send(1000);
    chk("fill8_val",  {31'd0, bus.period_out_valid}, 1);
    chk("fill8_out",  bus.period_out, 1000);
    chk("fill8_half", bus.half_period_out, 500);
    chk("fill8_lock", {31'd0, bus.locked}, 0);
    idle();
    chk("fill_val_pulse", {31'd0, bus.period_out_valid}, 0);

    // Lock after four in-tolerance samples
    send_n(1000, 3);
    chk("lock3", {31'd0, bus.locked}, 0);
    send(1000);
    chk("lock4", {31'd0, bus.locked}, 1);
    chk("lock4_val", {31'd0, bus.period_out_valid}, 1);

    // Loss of lock after two consecutive outliers
    send(2000);
    chk("miss1_rej",  {31'd0, bus.reject_pulse}, 1);
    chk("miss1_lock", {31'd0, bus.locked}, 1);
    chk("miss1_val",  {31'd0, bus.period_out_valid}, 0);
    send(2000);
    chk("miss2_rej",  {31'd0, bus.reject_pulse}, 1);
    chk("miss2_lock", {31'd0, bus.locked}, 0);
    chk("miss2_out",  bus.period_out, 1000);
    send(1000);
    chk("refill_val",  {31'd0, bus.period_out_valid}, 0);
    chk("refill_hold", bus.period_out, 1000);
    send_n(1000, 7);
    chk("refill8_val", {31'd0, bus.period_out_valid}, 1);
    send_n(1000, 4);
    chk("relock", {31'd0, bus.locked}, 1);

    // Tracking update while locked: sum 8000-1000+1100 = 8100
    send(1100);
    chk("trk_out",  bus.period_out, 1012);
    chk("trk_half", bus.half_period_out, 506);
    chk("trk_val",  {31'd0, bus.period_out_valid}, 1);
    chk("trk_lock", {31'd0, bus.locked}, 1);

    // Range boundaries in FILL: 100+10000+6*1000 = 16100 -> 2012
    pulse_reset();
    send(99);
    chk("min_m1_rej", {31'd0, bus.reject_pulse}, 1);
    send(10001);
    chk("max_p1_rej", {31'd0, bus.reject_pulse}, 1);
    send(100);
    chk("min_acc", {31'd0, bus.reject_pulse}, 0);
    send(10000);
    chk("max_acc", {31'd0, bus.reject_pulse}, 0);
    send_n(1000, 6);
    chk("bnd_out",  bus.period_out, 2012);
    chk("bnd_half", bus.half_period_out, 1006);

    // Tolerance edge from avg 1000 (tol 125)
    pulse_reset();
    send_n(1000, 8);
    chk("tol_fill", bus.period_out, 1000);
    send(1126);
    chk("tol_p1_rej", {31'd0, bus.reject_pulse}, 1);
    chk("tol_p1_out", bus.period_out, 1000);
    send(1125);
    chk("tol_eq_rej",  {31'd0, bus.reject_pulse}, 0);
    chk("tol_eq_val",  {31'd0, bus.period_out_valid}, 1);
    chk("tol_eq_out",  bus.period_out, 1015);
    chk("tol_eq_half", bus.half_period_out, 507);

    // Reset wins over a same-cycle strobe while tracking
    bus.period_in       = 1015;
    bus.period_in_valid = 1'b1;
    reset               = 1'b1;
    @(posedge clock);
    #1;
    reset               = 1'b0;
    bus.period_in_valid = 1'b0;
    chk("mrst_out",    bus.period_out, 0);
    chk("mrst_half",   bus.half_period_out, 0);
    chk("mrst_valid",  {31'd0, bus.period_out_valid}, 0);
    chk("mrst_reject", {31'd0, bus.reject_pulse}, 0);
    chk("mrst_locked", {31'd0, bus.locked}, 0);
    send_n(500, 7);
    chk("mrst_fill7", {31'd0, bus.period_out_valid}, 0);
    send(500);
    chk("mrst_fill8_val",  {31'd0, bus.period_out_valid}, 1);
    chk("mrst_fill8_out",  bus.period_out, 500);
    chk("mrst_fill8_half", bus.half_period_out, 250);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
